// File: rtl/jackal_audio_pkg.sv
// Shared audio-path types and rates for the filter chain and the 48 kHz decimator.
package jackal_audio_pkg;
  typedef logic signed [15:0] sample_t;

  localparam int JACKAL_SAMPLE_DIV  = 64;
  localparam int JACKAL_DECIM_RATIO = 16;
endpackage

// File: rtl/jackal_audio_decimator_if.sv
// Decimated-sample valid/ready link from the decimator to the audio output serializer.
interface jackal_audio_decimator_if;
  import jackal_audio_pkg::*;

  sample_t out_data;
  logic    out_valid;
  logic    out_ready;

  modport master (output out_data, output out_valid, input  out_ready);
  modport slave  (input  out_data, input  out_valid, output out_ready);
endinterface

// File: rtl/jackal_sample_fifo.sv
// Output word store for the decimator: DEPTH-entry circular FIFO with JACKAL_DECIM_FIFO_EN,
// otherwise a single holding register.
module jackal_sample_fifo
  import jackal_audio_pkg::*;
#(
  parameter int DEPTH = 4,
`ifdef JACKAL_DECIM_FIFO_EN
  parameter int LW    = $clog2(DEPTH) + 1
`else
  parameter int LW    = 1
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  sample_t       i_data,
  input  logic          i_pop,
  output sample_t       o_data,
  output logic          o_valid,
  output logic [LW-1:0] o_level,
  output logic          o_drop
);

  logic w_pop;
  assign w_pop = i_pop & o_valid;

`ifdef JACKAL_DECIM_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  sample_t     r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_en;

  // Extra pointer MSB tells full from empty when the address bits match.
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_wr_en = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr[AW-1:0]] <= i_data;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  assign o_data  = r_mem[r_rd[AW-1:0]];
  assign o_valid = ~w_empty;
  assign o_level = r_wr - r_rd;
  assign o_drop  = i_push & w_full & ~w_pop;
`else
  sample_t r_data;
  logic    r_full;

  // A push alongside a pop of the held word replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_push && (!r_full || w_pop)) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (w_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_full;
  assign o_level = r_full;
  assign o_drop  = i_push & r_full & ~w_pop;
`endif

endmodule

// File: rtl/jackal_audio_decimator.sv
// 768 kHz -> 48 kHz boxcar decimator (average of RATIO samples) feeding a valid/ready output.
// Define JACKAL_DECIM_FIFO_EN for a DEPTH-entry output FIFO instead of a single holding register.
module jackal_audio_decimator
  import jackal_audio_pkg::*;
#(
  parameter int DIV   = JACKAL_SAMPLE_DIV,
  parameter int RATIO = JACKAL_DECIM_RATIO,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  sample_t                    in,
  jackal_audio_decimator_if.master   out_if,
`ifdef JACKAL_DECIM_FIFO_EN
  output logic [$clog2(DEPTH):0]     level,
`else
  output logic                       level,
`endif
  output logic                       overflow
);

  localparam int SH    = $clog2(RATIO);
  localparam int ACC_W = 16 + SH;

  logic [9:0]              r_cnt;
  logic [SH-1:0]           r_phase;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_overflow;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_stb;
  logic                    w_last;
  logic                    w_drop;
  sample_t                 w_word;

  assign w_stb  = (r_cnt == 10'(DIV - 1));
  assign w_last = w_stb && (r_phase == SH'(RATIO - 1));
  assign w_sum  = r_acc + {{SH{in[15]}}, in};
  // Arithmetic shift floors toward -inf; the exact-width sum always fits back in 16 bits.
  assign w_word = sample_t'(w_sum >>> SH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_phase    <= '0;
      r_acc      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_cnt <= w_stb ? 10'd0 : r_cnt + 10'd1;
      if (w_stb) begin
        if (w_last) begin
          r_acc   <= '0;
          r_phase <= '0;
        end else begin
          r_acc   <= w_sum;
          r_phase <= r_phase + 1'b1;
        end
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;

  jackal_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_last),
    .i_data  (w_word),
    .i_pop   (out_if.out_ready),
    .o_data  (out_if.out_data),
    .o_valid (out_if.out_valid),
    .o_level (level),
    .o_drop  (w_drop)
  );

endmodule

// File: tb/tb_jackal_audio_decimator.sv
// Scoreboard bench for jackal_audio_decimator; FIFO cases follow JACKAL_DECIM_FIFO_EN.
module tb_jackal_audio_decimator;
  import jackal_audio_pkg::*;

  localparam int DIV   = JACKAL_SAMPLE_DIV;
  localparam int RATIO = JACKAL_DECIM_RATIO;
  localparam int DEPTH = 4;

  logic    clk   = 1'b0;
  logic    reset = 1'b1;
  sample_t in    = '0;
`ifdef JACKAL_DECIM_FIFO_EN
  logic [$clog2(DEPTH):0] level;
`else
  logic                   level;
`endif
  logic    overflow;

  jackal_audio_decimator_if dif ();

  jackal_audio_decimator #(.DIV(DIV), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .out_if   (dif),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;
  int exp_q[$];
  int m_cnt  = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Independent strobe-phase model: m_cnt is the count the DUT sees at the next edge.
  always @(posedge clk) begin
    if (reset) m_cnt <= 0;
    else       m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset && dif.out_valid && dif.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", dif.out_data, 99999);
      else                   chk("word", dif.out_data, exp_q.pop_front());
    end
  end

  function automatic int fdiv(input int s);
    return (s >= 0) ? s / RATIO : -((-s + RATIO - 1) / RATIO);
  endfunction

  // Called at posedge+1; returns just after the strobe edge that consumed v.
  task automatic send(input int v, input bit pulse);
    in = sample_t'(v);
    while (m_cnt != DIV - 1) begin
      @(posedge clk); #1;
    end
    if (pulse) dif.out_ready = 1'b1;
    @(posedge clk); #1;
    if (pulse) dif.out_ready = 1'b0;
  endtask

  task automatic group(input int a, input int b, input bit keep, input bit pulse_last);
    int sum = 0;
    for (int i = 0; i < RATIO; i++) sum += (i % 2 == 0) ? a : b;
    for (int i = 0; i < RATIO; i++) begin
      if (i == RATIO - 1 && keep) exp_q.push_back(fdiv(sum));
      send((i % 2 == 0) ? a : b, pulse_last && (i == RATIO - 1));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int r0, r1;
    dif.out_ready = 1'b1;
    do_reset();
    chk("rst_valid", dif.out_valid, 0);
    chk("rst_data",  dif.out_data,  0);
    chk("rst_level", level,         0);
    chk("rst_ovf",   overflow,      0);

    // First word: 16th strobe at clk 1023, visible right after that edge
    for (int i = 0; i < RATIO - 1; i++) send(1000, 1'b0);
    chk("pre_last_valid", dif.out_valid, 0);
    exp_q.push_back(1000);
    send(1000, 1'b0);
    chk("first_valid", dif.out_valid, 1);
    chk("first_data",  dif.out_data,  1000);
    @(posedge clk); #1;
    chk("popped_valid", dif.out_valid, 0);

    group(1000, 1000, 1'b1, 1'b0);
    chk("second_valid", dif.out_valid, 1);
    group(32767, -32768, 1'b1, 1'b0);
    group(-1, -1, 1'b1, 1'b0);
    group(32767, 32767, 1'b1, 1'b0);
    group(-32768, -32768, 1'b1, 1'b0);
    r0 = int'($urandom_range(0, 65535)) - 32768;
    r1 = int'($urandom_range(0, 65535)) - 32768;
    group(r0, r1, 1'b1, 1'b0);

    // Reset at strobe 7 throws away the partial 100s
    do_reset();
    for (int i = 0; i < 7; i++) send(100, 1'b0);
    do_reset();
    chk("midrst_valid", dif.out_valid, 0);
    group(200, 200, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

`ifdef JACKAL_DECIM_FIFO_EN
    do_reset();
    dif.out_ready = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      group(10 * k, 10 * k, 1'b1, 1'b0);
      chk("fill_level", level, k);
      chk("fill_ovf",   overflow, 0);
    end
    group(50, 50, 1'b0, 1'b0);
    chk("full_ovf",   overflow, 1);
    chk("full_level", level, DEPTH);
    chk("full_head",  dif.out_data, 10);
    dif.out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    chk("drain_level", level, 0);
    chk("sticky_ovf",  overflow, 1);
`else
    do_reset();
    dif.out_ready = 1'b0;
    group(10, 10, 1'b1, 1'b0);
    chk("hold_level", level, 1);
    chk("hold_ovf",   overflow, 0);
    group(20, 20, 1'b0, 1'b0);
    chk("drop_ovf",  overflow, 1);
    chk("drop_data", dif.out_data, 10);
    dif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sticky_ovf", overflow, 1);
    chk("pop_level",  level, 0);

    do_reset();
    chk("rst_ovf2", overflow, 0);
    dif.out_ready = 1'b0;
    group(30, 30, 1'b1, 1'b0);
    group(40, 40, 1'b1, 1'b1);
    chk("swap_ovf",   overflow, 0);
    chk("swap_level", level, 1);
    chk("swap_valid", dif.out_valid, 1);
    chk("swap_data",  dif.out_data, 40);
    dif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("swap_pop_level", level, 0);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
